xres_reset_sequencer: RTL and testbench

Digital controller for the chip-level external-reset pad. It drives the pad's enable, input-select and pull-up controls through a fixed power-up order, then synchronizes and glitch-filters the pad's level-shifted reset output. From the filtered reset it sequences staged reset release to the core reset domains and collapses all domains immediately on a new reset. It sits between the XRES pad cell and the core reset tree.

---
 rtl/xres_reset_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_xres_reset_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xres_reset_sequencer.sv
// XRES pad controller and staged reset sequencer.
// Sequences the pad bring-up, then runs the pad's reset output through a
// 2-flop synchronizer and a glitch filter. The filtered reset drives a staged
// release of the core reset domains and an immediate collapse on any new reset.
// The FSM state is exposed on dbg_state for observation.
module xres_reset_sequencer #(
  parameter int NUM_DOM    = 3,
  parameter int FILT_W     = 8,
  parameter int DLY_W      = 8,
  parameter int PAD_SETTLE = 16
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic               xres_n_in,
  input  logic               sw_rst_req,
  input  logic [FILT_W-1:0]  filt_len,
  input  logic [DLY_W-1:0]   stage_dly,
  output logic               pad_enable_h,
  output logic               pad_inp_sel_h,
  output logic               pad_disable_pullup_h,
  output logic [NUM_DOM-1:0] rst_dom_n,
  output logic               seq_busy,
  output logic [7:0]         xres_event_cnt,
  output logic [7:0]         glitch_cnt,
  output logic [1:0]         dbg_state
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int SET_W = (PAD_SETTLE > 1) ? $clog2(PAD_SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_PAD_INIT = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  // Synchronizer, filter and counter state
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              filt_q, filt_d;
  logic [FILT_W-1:0] fcnt_q, fcnt_d;
  logic [7:0]        glitch_q, glitch_d;
  logic [7:0]        event_q, event_d;

  // Sequencer state
  state_t             state_q;
  logic               pad_en_q;
  logic [SET_W-1:0]   settle_q;
  logic [DLY_W-1:0]   dcnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_DOM-1:0] rst_dom_q;
  logic               busy_q;
  logic               abort;

  // A release in progress (or a running system) collapses on filtered reset or software request
  assign abort = !filt_q || sw_rst_req;

  // Next-state for the synchronizer, the glitch filter and both event counters
  always_comb begin
    sync1_d  = xres_n_in;
    sync2_d  = sync1_q;
    filt_d   = filt_q;
    fcnt_d   = fcnt_q;
    glitch_d = glitch_q;
    event_d  = event_q;
    if (!pad_en_q) begin
      // The pad output is meaningless until the pad is enabled: hold in reset.
      sync1_d = 1'b0;
      sync2_d = 1'b0;
      filt_d  = 1'b0;
      fcnt_d  = '0;
    end else if (sync2_q == filt_q) begin
      // Input returned to the filtered level before the filter expired: a glitch.
      fcnt_d = '0;
      if (fcnt_q != '0 && glitch_q != 8'hFF) begin
        glitch_d = glitch_q + 8'd1;
      end
    end else if (fcnt_q == filt_len) begin
      filt_d = sync2_q;
      fcnt_d = '0;
      if (filt_q && !sync2_q && event_q != 8'hFF) begin
        event_d = event_q + 8'd1;
      end
    end else begin
      fcnt_d = fcnt_q + FILT_W'(1);
    end
  end

  // Register the synchronizer, filter and counters
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      filt_q   <= 1'b0;
      fcnt_q   <= '0;
      glitch_q <= '0;
      event_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      glitch_q <= glitch_d;
      event_q  <= event_d;
    end
  end

  // Pad bring-up and staged domain release FSM with registered outputs
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_PAD_INIT;
      pad_en_q  <= 1'b0;
      settle_q  <= '0;
      dcnt_q    <= '0;
      idx_q     <= '0;
      rst_dom_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_PAD_INIT: begin
          rst_dom_q <= '0;
          if (settle_q == SET_W'(PAD_SETTLE - 1)) begin
            pad_en_q <= 1'b1;
            state_q  <= ST_ASSERT;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end
        ST_ASSERT: begin
          rst_dom_q <= '0;
          if (filt_q && !sw_rst_req) begin
            state_q <= ST_RELEASE;
            dcnt_q  <= stage_dly;
            idx_q   <= '0;
          end
        end
        ST_RELEASE: begin
          // Abort wins over a release that would otherwise happen this edge.
          if (abort) begin
            state_q   <= ST_ASSERT;
            rst_dom_q <= '0;
          end else if (dcnt_q == '0) begin
            for (int i = 0; i < NUM_DOM; i++) begin
              if (idx_q == IDX_W'(i)) begin
                rst_dom_q[i] <= 1'b1;
              end
            end
            if (idx_q == IDX_W'(NUM_DOM - 1)) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
            end else begin
              idx_q  <= idx_q + IDX_W'(1);
              dcnt_q <= stage_dly;
            end
          end else begin
            dcnt_q <= dcnt_q - DLY_W'(1);
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q   <= ST_ASSERT;
            rst_dom_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_PAD_INIT;
          rst_dom_q <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign pad_enable_h         = pad_en_q;
  assign pad_inp_sel_h        = 1'b0;
  assign pad_disable_pullup_h = 1'b0;
  assign rst_dom_n            = rst_dom_q;
  assign seq_busy             = busy_q;
  assign xres_event_cnt       = event_q;
  assign glitch_cnt           = glitch_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_xres_reset_sequencer.sv
// Bench for xres_reset_sequencer: each scenario task drives the pad/software
// inputs, pushes the expected (edge, rst_dom_n) pairs onto exp_q, and compares
// them against the domain changes captured by the monitor into obs_q.
module tb_xres_reset_sequencer;

  localparam int NUM_DOM = 3;
  localparam int W       = 32 + NUM_DOM;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       resetb;
  logic       xres_n_in;
  logic       sw_rst_req;
  logic [7:0] filt_len;
  logic [7:0] stage_dly;

  logic               pad_enable_h;
  logic               pad_inp_sel_h;
  logic               pad_disable_pullup_h;
  logic [NUM_DOM-1:0] rst_dom_n;
  logic               seq_busy;
  logic [7:0]         xres_event_cnt;
  logic [7:0]         glitch_cnt;
  logic [1:0]         dbg_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  xres_reset_sequencer #(
    .NUM_DOM(NUM_DOM), .FILT_W(8), .DLY_W(8), .PAD_SETTLE(16)
  ) dut (
    .clock(clock),
    .resetb(resetb),
    .xres_n_in(xres_n_in),
    .sw_rst_req(sw_rst_req),
    .filt_len(filt_len),
    .stage_dly(stage_dly),
    .pad_enable_h(pad_enable_h),
    .pad_inp_sel_h(pad_inp_sel_h),
    .pad_disable_pullup_h(pad_disable_pullup_h),
    .rst_dom_n(rst_dom_n),
    .seq_busy(seq_busy),
    .xres_event_cnt(xres_event_cnt),
    .glitch_cnt(glitch_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [NUM_DOM-1:0] prev_dom = '0;
  int errors = 0;
  int checks = 0;
  int base_cyc = 0;

  // Monitor: log every rst_dom_n change with the number of the edge that caused it
  always @(negedge clock) begin
    if (rst_dom_n !== prev_dom) obs_q.push_back({cyc, rst_dom_n});
    prev_dom <= rst_dom_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int edge_n, input logic [NUM_DOM-1:0] dom);
    exp_q.push_back({edge_n, dom});
  endtask

  task automatic flush();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_events(input int n, input string name, input int budget);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    int waited;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < budget) begin
        tick();
        waited++;
      end
      exp = '0;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s[%0d]: no rst_dom_n change within %0d cycles, expected edge %0d value %b",
                 name, i, budget, exp[W-1:NUM_DOM] - base_cyc, exp[NUM_DOM-1:0]);
      end else begin
        got = obs_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL %s[%0d]: got edge %0d value %b, expected edge %0d value %b", name, i,
                   got[W-1:NUM_DOM] - base_cyc, got[NUM_DOM-1:0],
                   exp[W-1:NUM_DOM] - base_cyc, exp[NUM_DOM-1:0]);
        end
      end
    end
  endtask

  // One low pulse on the pad output, n edges wide, starting at the next edge
  task automatic pad_pulse(input int n);
    xres_n_in = 1'b0;
    repeat (n) tick();
    xres_n_in = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetb = 1'b0; xres_n_in = 1'b1; sw_rst_req = 1'b0;
    filt_len = 8'd4; stage_dly = 8'd3;
    repeat (3) tick();
    checks++; if (pad_enable_h !== 1'b0) begin errors++; $display("FAIL reset_pad_en: got %b expected 0", pad_enable_h); end
    checks++; if (pad_inp_sel_h !== 1'b0) begin errors++; $display("FAIL reset_inp_sel: got %b expected 0", pad_inp_sel_h); end
    checks++; if (pad_disable_pullup_h !== 1'b0) begin errors++; $display("FAIL reset_pullup: got %b expected 0", pad_disable_pullup_h); end
    checks++; if (rst_dom_n !== 3'b000) begin errors++; $display("FAIL reset_dom: got %b expected 000", rst_dom_n); end
    checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", seq_busy); end
    checks++; if (xres_event_cnt !== 8'd0) begin errors++; $display("FAIL reset_event_cnt: got %0d expected 0", xres_event_cnt); end
    checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL reset_glitch_cnt: got %0d expected 0", glitch_cnt); end
    resetb = 1'b1;
    base_cyc = cyc;
  endtask

  task automatic test_bringup();
    flush();
    // pad enabled at edge 16, sampled at 17, filt 4 edges later, staged by 4
    push_exp(base_cyc + 28, 3'b001);
    push_exp(base_cyc + 32, 3'b011);
    push_exp(base_cyc + 36, 3'b111);
    while (cyc < base_cyc + 15) tick();
    checks++; if (pad_enable_h !== 1'b0) begin errors++; $display("FAIL bringup_pad_en_e15: got %b expected 0", pad_enable_h); end
    tick();
    checks++; if (pad_enable_h !== 1'b1) begin errors++; $display("FAIL bringup_pad_en_e16: got %b expected 1", pad_enable_h); end
    checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL bringup_busy_e16: got %b expected 1", seq_busy); end
    checks++; if (pad_inp_sel_h !== 1'b0 || pad_disable_pullup_h !== 1'b0) begin
      errors++; $display("FAIL bringup_pad_ctrl: got inp_sel %b pullup %b expected 0 0", pad_inp_sel_h, pad_disable_pullup_h);
    end
    check_events(3, "bringup_release", 40);
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL bringup_busy_run: got %b expected 0", seq_busy); end
  endtask

  task automatic test_run_glitch();
    flush();
    pad_pulse(3);
    repeat (12) tick();
    checks++; if (obs_q.size() != 0 || rst_dom_n !== 3'b111) begin
      errors++; $display("FAIL glitch_dom_stable: got %0d changes, final %b expected 0 changes, 111", obs_q.size(), rst_dom_n);
    end
    checks++; if (glitch_cnt !== 8'd1) begin errors++; $display("FAIL glitch_cnt: got %0d expected 1", glitch_cnt); end
    checks++; if (xres_event_cnt !== 8'd0) begin errors++; $display("FAIL glitch_event_cnt: got %0d expected 0", xres_event_cnt); end
  endtask

  task automatic test_run_pulse();
    int k;
    flush();
    k = cyc;
    push_exp(k + 8, 3'b000);
    push_exp(k + 20, 3'b001);
    push_exp(k + 24, 3'b011);
    push_exp(k + 28, 3'b111);
    pad_pulse(8);
    check_events(4, "pulse_assert_release", 30);
    checks++; if (xres_event_cnt !== 8'd1) begin errors++; $display("FAIL pulse_event_cnt: got %0d expected 1", xres_event_cnt); end
    checks++; if (glitch_cnt !== 8'd1) begin errors++; $display("FAIL pulse_glitch_cnt: got %0d expected 1", glitch_cnt); end
  endtask

  task automatic test_sw_abort();
    int a;
    flush();
    a = cyc;
    sw_rst_req = 1'b1;
    push_exp(a + 1, 3'b000);
    check_events(1, "sw_assert", 10);
    a = cyc;
    sw_rst_req = 1'b0;
    push_exp(a + 5, 3'b001);
    push_exp(a + 6, 3'b000);
    repeat (5) tick();
    sw_rst_req = 1'b1;
    check_events(2, "sw_abort_mid_release", 10);
    repeat (2) tick();
    a = cyc;
    sw_rst_req = 1'b0;
    push_exp(a + 5, 3'b001);
    push_exp(a + 9, 3'b011);
    push_exp(a + 13, 3'b111);
    check_events(3, "sw_restart", 30);
  endtask

  task automatic test_fast();
    int k;
    filt_len = 8'd0;
    stage_dly = 8'd0;
    tick();
    flush();
    k = cyc;
    push_exp(k + 4, 3'b000);
    push_exp(k + 6, 3'b001);
    push_exp(k + 7, 3'b011);
    push_exp(k + 8, 3'b111);
    pad_pulse(1);
    check_events(4, "fast_glitch_propagates", 20);
    checks++; if (xres_event_cnt !== 8'd2) begin errors++; $display("FAIL fast_event_cnt: got %0d expected 2", xres_event_cnt); end
    checks++; if (glitch_cnt !== 8'd1) begin errors++; $display("FAIL fast_glitch_cnt: got %0d expected 1", glitch_cnt); end
  endtask

  task automatic test_saturate();
    filt_len = 8'd4;
    tick();
    flush();
    for (int i = 0; i < 260; i++) begin
      pad_pulse(1 + $urandom_range(0, 2));
      repeat (3) tick();
    end
    repeat (8) tick();
    checks++; if (glitch_cnt !== 8'd255) begin errors++; $display("FAIL glitch_saturate: got %0d expected 255", glitch_cnt); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_burst_dom: got %0d domain changes expected 0", obs_q.size()); end
    checks++; if (xres_event_cnt !== 8'd2) begin errors++; $display("FAIL glitch_burst_event_cnt: got %0d expected 2", xres_event_cnt); end
    filt_len = 8'd0;
    for (int i = 0; i < 260; i++) begin
      pad_pulse(1);
      tick();
    end
    repeat (20) tick();
    checks++; if (xres_event_cnt !== 8'd255) begin errors++; $display("FAIL event_saturate: got %0d expected 255", xres_event_cnt); end
    checks++; if (glitch_cnt !== 8'd255) begin errors++; $display("FAIL glitch_hold_255: got %0d expected 255", glitch_cnt); end
    checks++; if (seq_busy !== 1'b0 || rst_dom_n !== 3'b111) begin
      errors++; $display("FAIL saturate_run: got busy %b dom %b expected 0 111", seq_busy, rst_dom_n);
    end
  endtask

  task automatic test_async_reset();
    int k;
    stage_dly = 8'd3;
    tick();
    flush();
    k = cyc;
    push_exp(k + 4, 3'b000);
    push_exp(k + 9, 3'b001);
    pad_pulse(1);
    check_events(2, "pre_reset_release", 20);
    checks++; if (seq_busy !== 1'b1 || rst_dom_n !== 3'b001 || pad_enable_h !== 1'b1) begin
      errors++; $display("FAIL mid_release_state: got busy %b dom %b pad_en %b expected 1 001 1", seq_busy, rst_dom_n, pad_enable_h);
    end
    #2;
    resetb = 1'b0;
    #1;
    checks++; if (rst_dom_n !== 3'b000) begin errors++; $display("FAIL async_dom: got %b expected 000", rst_dom_n); end
    checks++; if (pad_enable_h !== 1'b0) begin errors++; $display("FAIL async_pad_en: got %b expected 0", pad_enable_h); end
    checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL async_busy: got %b expected 1", seq_busy); end
    checks++; if (xres_event_cnt !== 8'd0) begin errors++; $display("FAIL async_event_cnt: got %0d expected 0", xres_event_cnt); end
    checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL async_glitch_cnt: got %0d expected 0", glitch_cnt); end
    tick();
    resetb = 1'b1;
    repeat (4) tick();
    checks++; if (pad_enable_h !== 1'b0 || rst_dom_n !== 3'b000) begin
      errors++; $display("FAIL post_reset_init: got pad_en %b dom %b expected 0 000", pad_enable_h, rst_dom_n);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_bringup();
    test_run_glitch();
    test_run_pulse();
    test_sw_abort();
    test_fast();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
